// File: rtl/jogo_memoria_param.sv
`timescale 1ns/1ps
// Memory-sequence game engine: plays a growing sequence on the LEDs and checks the
// player's presses. New entries come from an LFSR (modo 0) or are recorded by the player (modo 1).
module jogo_memoria_param #(
    parameter int N_BUTTONS      = 4,
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int SHOW_CYCLES    = 1000,
    localparam int ADDR_W        = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iniciar,
    input  logic                 modo,
    input  logic [N_BUTTONS-1:0] botoes,
    output logic [N_BUTTONS-1:0] leds,
    output logic                 acertou,
    output logic                 errou,
    output logic                 timeout,
    output logic                 pronto,
    output logic [3:0]           db_estado,
    output logic [ADDR_W-1:0]    db_rodada,
    output logic [ADDR_W-1:0]    db_endereco,
    output logic [N_BUTTONS-1:0] db_jogada
);

    localparam int TMR_MAX = (TIMEOUT_CYCLES > SHOW_CYCLES) ? TIMEOUT_CYCLES : SHOW_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARA        = 4'h1,
        MOSTRA         = 4'h2,
        APAGA          = 4'h3,
        ESPERA         = 4'h4,
        COMPARA        = 4'h5,
        PROXIMO        = 4'h6,
        ESCREVE_ESPERA = 4'h7,
        ESCREVE        = 4'h8,
        PROX_RODADA    = 4'h9,
        FIM_ACERTO     = 4'hA,
        FIM_ERRO       = 4'hB,
        FIM_TIMEOUT    = 4'hC
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [15:0]          lfsr;
    logic [N_BUTTONS-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]    rodada;
    logic [ADDR_W-1:0]    endereco;
    logic [TMR_W-1:0]     timer;
    logic                 modo_r;
    logic [N_BUTTONS-1:0] botoes_prev;
    logic [N_BUTTONS-1:0] jogada;

    logic                 press;
    logic                 one_hot;
    logic                 show_done;
    logic                 to_done;
    logic                 rodada_last;
    logic [31:0]          lfsr_sel;
    logic [N_BUTTONS-1:0] entry;
    logic [N_BUTTONS-1:0] mem_rd;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_wa;
    logic [N_BUTTONS-1:0] mem_wd;

    // A press is the first non-zero cycle after an all-released cycle, so holding counts once.
    assign press       = (botoes != '0) && (botoes_prev == '0);
    assign one_hot     = (botoes & (botoes - 1'b1)) == '0;
    assign show_done   = (timer == TMR_W'(SHOW_CYCLES - 1));
    assign to_done     = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign rodada_last = (rodada == ADDR_W'(DEPTH - 1));
    assign lfsr_sel    = 32'(lfsr) % 32'(N_BUTTONS);
    assign entry       = N_BUTTONS'(1) << lfsr_sel;
    assign mem_rd      = mem[endereco];

    always_comb begin
        state_next = state;
        case (state)
            INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                if (iniciar) state_next = PREPARA;
            PREPARA:
                state_next = modo_r ? ESCREVE_ESPERA : MOSTRA;
            MOSTRA:
                if (show_done) state_next = APAGA;
            APAGA:
                if (show_done) state_next = (endereco < rodada) ? MOSTRA : ESPERA;
            ESPERA:
                if (press)        state_next = COMPARA;
                else if (to_done) state_next = FIM_TIMEOUT;
            COMPARA:
                if (jogada != mem_rd)         state_next = FIM_ERRO;
                else if (endereco < rodada)   state_next = PROXIMO;
                else                          state_next = PROX_RODADA;
            PROXIMO:
                state_next = ESPERA;
            PROX_RODADA:
                if (rodada_last) state_next = FIM_ACERTO;
                else             state_next = modo_r ? ESCREVE_ESPERA : MOSTRA;
            ESCREVE_ESPERA:
                if (press)        state_next = one_hot ? ESCREVE : FIM_ERRO;
                else if (to_done) state_next = FIM_TIMEOUT;
            ESCREVE:
                state_next = MOSTRA;
            default:
                state_next = INICIAL;
        endcase
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = entry;
        if (state == PREPARA && !modo_r) begin
            mem_we = 1'b1;
        end else if (state == PROX_RODADA && !rodada_last && !modo_r) begin
            mem_we = 1'b1;
            mem_wa = rodada + 1'b1;
        end else if (state == ESCREVE) begin
            mem_we = 1'b1;
            mem_wa = endereco;
            mem_wd = jogada;
        end
    end

    // Sequence storage has no reset; only entries already written are ever read back.
    always_ff @(posedge clock) begin
        if (reset && mem_we) mem[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= INICIAL;
            lfsr        <= 16'hACE1;
            rodada      <= '0;
            endereco    <= '0;
            timer       <= '0;
            modo_r      <= 1'b0;
            botoes_prev <= '0;
            jogada      <= '0;
            acertou     <= 1'b0;
            errou       <= 1'b0;
            timeout     <= 1'b0;
            pronto      <= 1'b0;
        end else begin
            state       <= state_next;
            lfsr        <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            botoes_prev <= botoes;
            timer       <= (state_next != state) ? '0 : timer + 1'b1;
            if (press) jogada <= botoes;
            acertou <= (state_next == FIM_ACERTO);
            errou   <= (state_next == FIM_ERRO) || (state_next == FIM_TIMEOUT);
            timeout <= (state_next == FIM_TIMEOUT);
            pronto  <= (state_next == FIM_ACERTO) || (state_next == FIM_ERRO) ||
                       (state_next == FIM_TIMEOUT);
            case (state)
                INICIAL, FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                    if (iniciar) begin
                        rodada   <= '0;
                        endereco <= '0;
                        modo_r   <= modo;
                    end
                APAGA:
                    if (show_done) endereco <= (endereco < rodada) ? endereco + 1'b1 : '0;
                PROXIMO:
                    endereco <= endereco + 1'b1;
                PROX_RODADA:
                    if (!rodada_last) begin
                        rodada   <= rodada + 1'b1;
                        endereco <= modo_r ? rodada + 1'b1 : '0;
                    end
                ESCREVE:
                    endereco <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        leds = '0;
        case (state)
            MOSTRA:                 leds = mem_rd;
            ESPERA, ESCREVE_ESPERA: leds = botoes;
            default: ;
        endcase
    end

    assign db_estado   = state;
    assign db_rodada   = rodada;
    assign db_endereco = endereco;
    assign db_jogada   = jogada;

endmodule
